// File: rtl/keccak_lane_buffer_pkg.sv
// rtl/keccak_lane_buffer_pkg.sv - shared constants and state type for the keccak lane buffer
package keccak_lane_buffer_pkg;

    localparam int          KECCAK_LANE_W  = 64;
    localparam logic [63:0] SHA3_PAD_FIRST = 64'h06;
    localparam logic [63:0] SHA3_PAD_LAST  = 64'h8000_0000_0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        ABSORB,
        WAIT_DIG,
        SQUEEZE,
        DONE
    } kbuf_state_t;

endpackage

// File: rtl/keccak_lane_buffer_if.sv
// rtl/keccak_lane_buffer_if.sv - accelerator FSM <-> lane buffer handshake
interface keccak_lane_buffer_if
    import keccak_lane_buffer_pkg::*;
#(
    parameter int LANE_W = KECCAK_LANE_W
) ();

    logic              start;
    logic [LANE_W-1:0] din;
    logic              din_valid;
    logic              last_block;
    logic              buffer_full;
    logic              ready;
    logic [LANE_W-1:0] dout;
    logic              dout_valid;
    logic              drop_err;

    // Accelerator FSM side
    modport master (
        output start, din, din_valid, last_block,
        input  buffer_full, ready, dout, dout_valid, drop_err
    );

    // Lane buffer side
    modport slave (
        input  start, din, din_valid, last_block,
        output buffer_full, ready, dout, dout_valid, drop_err
    );

endinterface

// File: rtl/keccak_lane_buffer_digest_shifter.sv
// rtl/keccak_lane_buffer_digest_shifter.sv - latches digest lanes and streams them out one per cycle
module keccak_digest_shifter
    import keccak_lane_buffer_pkg::*;
#(
    parameter int LANE_W    = KECCAK_LANE_W,
    parameter int OUT_LANES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_i,
    input  logic                        load_i,
    input  logic [OUT_LANES*LANE_W-1:0] data_i,
    output logic [LANE_W-1:0]           dout_o,
    output logic                        dout_valid_o,
    output logic                        last_o
);

    localparam int                CNT_W   = $clog2(OUT_LANES + 1);
    localparam logic [CNT_W-1:0]  OUT_CNT = CNT_W'(OUT_LANES);

    logic [OUT_LANES*LANE_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    // Next state: abort wins, then load, otherwise shift down one lane while lanes remain
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (load_i) begin
            data_d = data_i;
            cnt_d  = OUT_CNT;
        end else if (cnt_q != '0) begin
            data_d = data_q >> LANE_W;
            cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    // Shift register and remaining-lane counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout_valid_o = (cnt_q != '0);
    assign dout_o       = dout_valid_o ? data_q[LANE_W-1:0] : '0;
    assign last_o       = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/keccak_lane_buffer.sv
// rtl/keccak_lane_buffer.sv - collects message lanes, pads, feeds Keccak core, streams digest
module keccak_lane_buffer
    import keccak_lane_buffer_pkg::*;
#(
    parameter int LANE_W     = KECCAK_LANE_W,
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    keccak_lane_buffer_if.slave          fsm_if,
    output logic [RATE_LANES*LANE_W-1:0] blk_data_o,
    output logic                         blk_valid_o,
    output logic                         blk_last_o,
    input  logic                         blk_ack_i,
    input  logic [OUT_LANES*LANE_W-1:0]  digest_in_i,
    input  logic                         digest_valid_i
);

    localparam int               CNT_W    = $clog2(RATE_LANES + 1);
    localparam logic [CNT_W-1:0] RATE_CNT = CNT_W'(RATE_LANES);

    kbuf_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  msg_end_q, msg_end_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [LANE_W-1:0] buf_q [RATE_LANES];
    logic [LANE_W-1:0] buf_d [RATE_LANES];
    logic              pad_pend_q, pad_pend_d;
    logic              blk_valid_q, blk_valid_d;
    logic              blk_last_q, blk_last_d;
    logic              drop_err_q, drop_err_d;
    logic              ack_fire;
    logic              sh_load;
    logic              sh_last;
    logic              buffer_full;

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign ack_fire = (state_q == ABSORB) && blk_valid_q && blk_ack_i;
    assign sh_load  = (state_q == WAIT_DIG) && digest_valid_i && !fsm_if.start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start overrides every other input
    always_comb begin
        state_d = state_q;
        if (fsm_if.start) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (fsm_if.last_block)
                        state_d = PAD;
                    else if (fsm_if.din_valid && cnt_inc == RATE_CNT)
                        state_d = ABSORB;
                end
                PAD:      state_d = ABSORB;
                ABSORB: begin
                    if (ack_fire) begin
                        if (blk_last_q)      state_d = WAIT_DIG;
                        else if (pad_pend_q) state_d = ABSORB;
                        else                 state_d = FILL;
                    end
                end
                WAIT_DIG: if (digest_valid_i) state_d = SQUEEZE;
                SQUEEZE:  if (sh_last)        state_d = DONE;
                IDLE, DONE: state_d = state_q;
                default:  state_d = IDLE;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        buffer_full   = (state_q != FILL);
        fsm_if.ready  = (state_q == DONE);
    end

    // Datapath next state: lane writes, padding, block hand-off bookkeeping
    always_comb begin
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        msg_end_d   = msg_end_q;
        pad_pend_d  = pad_pend_q;
        blk_valid_d = blk_valid_q;
        blk_last_d  = blk_last_q;
        drop_err_d  = drop_err_q;
        if (fsm_if.start) begin
            for (int i = 0; i < RATE_LANES; i++) buf_d[i] = '0;
            cnt_d       = '0;
            msg_end_d   = '0;
            pad_pend_d  = 1'b0;
            blk_valid_d = 1'b0;
            blk_last_d  = 1'b0;
            drop_err_d  = 1'b0;
        end else begin
            if (fsm_if.din_valid && buffer_full) drop_err_d = 1'b1;
            case (state_q)
                FILL: begin
                    if (fsm_if.din_valid) begin
                        for (int i = 0; i < RATE_LANES; i++)
                            if (cnt_q == CNT_W'(i)) buf_d[i] = fsm_if.din;
                        cnt_d = cnt_inc;
                    end
                    if (fsm_if.last_block) begin
                        msg_end_d = fsm_if.din_valid ? cnt_inc : cnt_q;
                    end else if (fsm_if.din_valid && cnt_inc == RATE_CNT) begin
                        blk_valid_d = 1'b1;
                        blk_last_d  = 1'b0;
                    end
                end
                PAD: begin
                    // A full final block goes out as-is; padding follows in its own block
                    if (msg_end_q == RATE_CNT) begin
                        pad_pend_d = 1'b1;
                        blk_last_d = 1'b0;
                    end else begin
                        for (int i = 0; i < RATE_LANES; i++)
                            if (msg_end_q == CNT_W'(i)) buf_d[i] = buf_d[i] | SHA3_PAD_FIRST;
                        buf_d[RATE_LANES-1] = buf_d[RATE_LANES-1] | SHA3_PAD_LAST;
                        blk_last_d = 1'b1;
                    end
                    blk_valid_d = 1'b1;
                end
                ABSORB: begin
                    if (ack_fire) begin
                        blk_valid_d = 1'b0;
                        if (!blk_last_q) begin
                            for (int i = 0; i < RATE_LANES; i++) buf_d[i] = '0;
                            cnt_d = '0;
                            if (pad_pend_q) begin
                                buf_d[0]            = SHA3_PAD_FIRST;
                                buf_d[RATE_LANES-1] = buf_d[RATE_LANES-1] | SHA3_PAD_LAST;
                                pad_pend_d          = 1'b0;
                                blk_last_d          = 1'b1;
                            end
                        end
                    end else if (!blk_valid_q) begin
                        // re-offer after the pad-only block was loaded
                        blk_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RATE_LANES; i++) buf_q[i] <= '0;
            cnt_q       <= '0;
            msg_end_q   <= '0;
            pad_pend_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            msg_end_q   <= msg_end_d;
            pad_pend_q  <= pad_pend_d;
            blk_valid_q <= blk_valid_d;
            blk_last_q  <= blk_last_d;
            drop_err_q  <= drop_err_d;
        end
    end

    for (genvar g = 0; g < RATE_LANES; g++) begin : g_blk
        assign blk_data_o[g*LANE_W +: LANE_W] = buf_q[g];
    end

    assign blk_valid_o        = blk_valid_q;
    assign blk_last_o         = blk_last_q;
    assign fsm_if.buffer_full = buffer_full;
    assign fsm_if.drop_err    = drop_err_q;

    keccak_digest_shifter #(
        .LANE_W    (LANE_W),
        .OUT_LANES (OUT_LANES)
    ) u_shifter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (fsm_if.start),
        .load_i       (sh_load),
        .data_i       (digest_in_i),
        .dout_o       (fsm_if.dout),
        .dout_valid_o (fsm_if.dout_valid),
        .last_o       (sh_last)
    );

endmodule

// File: tb/tb_keccak_lane_buffer.sv
// tb/tb_keccak_lane_buffer.sv - directed self-checking bench for keccak_lane_buffer
module tb_keccak_lane_buffer;

    localparam logic [63:0] P_FIRST = 64'h06;
    localparam logic [63:0] P_LAST  = 64'h8000_0000_0000_0000;

    logic          clk;
    logic          rst_n;
    logic [1087:0] blk_data;
    logic          blk_valid;
    logic          blk_last;
    logic          blk_ack;
    logic [255:0]  digest_in;
    logic          digest_valid;

    int n_checks;
    int n_errors;
    logic [63:0] exp_blk [17];

    keccak_lane_buffer_if #(.LANE_W(64)) kif ();

    keccak_lane_buffer #(
        .LANE_W     (64),
        .RATE_LANES (17),
        .OUT_LANES  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fsm_if         (kif),
        .blk_data_o     (blk_data),
        .blk_valid_o    (blk_valid),
        .blk_last_o     (blk_last),
        .blk_ack_i      (blk_ack),
        .digest_in_i    (digest_in),
        .digest_valid_i (digest_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        kif.start = 1'b1;
        step();
        kif.start = 1'b0;
    endtask

    task automatic send_lane(input logic [63:0] v, input logic last);
        kif.din        = v;
        kif.din_valid  = 1'b1;
        kif.last_block = last;
        step();
        kif.din_valid  = 1'b0;
        kif.last_block = 1'b0;
    endtask

    task automatic send_lanes(input int n, input logic [63:0] base, input logic last);
        for (int k = 0; k < n; k++) send_lane(base + 64'(k), last && (k == n - 1));
    endtask

    task automatic wait_blk(input string tag);
        int n;
        n = 0;
        while (blk_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, " blk_valid"}, 64'(blk_valid), 64'd1);
    endtask

    task automatic ack_blk();
        blk_ack = 1'b1;
        step();
        blk_ack = 1'b0;
    endtask

    task automatic clr_exp();
        for (int i = 0; i < 17; i++) exp_blk[i] = '0;
    endtask

    task automatic check_block(input string tag, input logic last);
        logic [63:0] ln;
        chk({tag, " blk_last"}, 64'(blk_last), 64'(last));
        for (int i = 0; i < 17; i++) begin
            ln = blk_data[i*64 +: 64];
            chk($sformatf("%s lane%0d", tag, i), ln, exp_blk[i]);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        kif.start      = 1'b0;
        kif.din        = '0;
        kif.din_valid  = 1'b0;
        kif.last_block = 1'b0;
        blk_ack        = 1'b0;
        digest_in      = '0;
        digest_valid   = 1'b0;
        step(); step(); step();

        chk("rst buffer_full", 64'(kif.buffer_full), 64'd1);
        chk("rst ready",       64'(kif.ready),       64'd0);
        chk("rst dout",        kif.dout,             64'd0);
        chk("rst dout_valid",  64'(kif.dout_valid),  64'd0);
        chk("rst drop_err",    64'(kif.drop_err),    64'd0);
        chk("rst blk_valid",   64'(blk_valid),       64'd0);
        chk("rst blk_last",    64'(blk_last),        64'd0);
        rst_n = 1'b1;
        step();

        // zero-length message
        do_start();
        chk("zl buffer_full", 64'(kif.buffer_full), 64'd0);
        kif.last_block = 1'b1;
        step();
        kif.last_block = 1'b0;
        wait_blk("zl");
        clr_exp();
        exp_blk[0]  = P_FIRST;
        exp_blk[16] = P_LAST;
        check_block("zl", 1'b1);
        ack_blk();
        chk("zl blk_valid drop", 64'(blk_valid), 64'd0);

        // three lanes then digest stream
        do_start();
        send_lanes(3, 64'd1, 1'b1);
        wait_blk("l3");
        clr_exp();
        exp_blk[0]  = 64'd1;
        exp_blk[1]  = 64'd2;
        exp_blk[2]  = 64'd3;
        exp_blk[3]  = P_FIRST;
        exp_blk[16] = P_LAST;
        check_block("l3", 1'b1);
        ack_blk();
        digest_in    = {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA};
        digest_valid = 1'b1;
        step();
        digest_valid = 1'b0;
        chk("sq v0", 64'(kif.dout_valid), 64'd1);
        chk("sq d0", kif.dout, 64'hAAAA);
        step();
        chk("sq d1", kif.dout, 64'hBBBB);
        step();
        chk("sq d2", kif.dout, 64'hCCCC);
        step();
        chk("sq d3", kif.dout, 64'hDDDD);
        chk("sq ready early", 64'(kif.ready), 64'd0);
        step();
        chk("sq end valid", 64'(kif.dout_valid), 64'd0);
        chk("sq ready",     64'(kif.ready),      64'd1);
        chk("sq dout zero", kif.dout,            64'd0);
        digest_valid = 1'b1;
        step();
        digest_valid = 1'b0;
        step();
        chk("done ignores digest", 64'(kif.dout_valid), 64'd0);

        // 16 lanes: both pad bytes share the last lane
        do_start();
        send_lanes(16, 64'h100, 1'b1);
        wait_blk("l16");
        clr_exp();
        for (int i = 0; i < 16; i++) exp_blk[i] = 64'h100 + 64'(i);
        exp_blk[16] = 64'h8000_0000_0000_0006;
        check_block("l16", 1'b1);
        ack_blk();

        // 17 lanes: full block then pad-only block
        do_start();
        send_lanes(17, 64'h200, 1'b1);
        wait_blk("l17a");
        for (int i = 0; i < 17; i++) exp_blk[i] = 64'h200 + 64'(i);
        check_block("l17a", 1'b0);
        ack_blk();
        chk("l17 gap", 64'(blk_valid), 64'd0);
        wait_blk("l17b");
        clr_exp();
        exp_blk[0]  = P_FIRST;
        exp_blk[16] = P_LAST;
        check_block("l17b", 1'b1);
        ack_blk();

        // 40 lanes over three blocks
        do_start();
        send_lanes(17, 64'h300, 1'b0);
        wait_blk("l40a");
        chk("l40a last", 64'(blk_last), 64'd0);
        chk("l40a lane0", blk_data[63:0], 64'h300);
        ack_blk();
        send_lanes(17, 64'h311, 1'b0);
        wait_blk("l40b");
        chk("l40b last", 64'(blk_last), 64'd0);
        chk("l40b lane16", blk_data[16*64 +: 64], 64'h321);
        ack_blk();
        send_lanes(6, 64'h322, 1'b1);
        wait_blk("l40c");
        clr_exp();
        for (int i = 0; i < 6; i++) exp_blk[i] = 64'h322 + 64'(i);
        exp_blk[6]  = P_FIRST;
        exp_blk[16] = P_LAST;
        check_block("l40c", 1'b1);
        // lane offered while the block waits for the core
        send_lane(64'hDEAD, 1'b0);
        chk("drop_err set", 64'(kif.drop_err), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk("hold valid", 64'(blk_valid),       64'd1);
            chk("hold full",  64'(kif.buffer_full), 64'd1);
            chk("hold lane0", blk_data[63:0],       64'h322);
            step();
        end
        check_block("l40c held", 1'b1);
        ack_blk();

        // abort mid-squeeze
        digest_in    = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
        digest_valid = 1'b1;
        step();
        digest_valid = 1'b0;
        chk("ab d0", kif.dout, 64'hE0);
        step();
        chk("ab d1", kif.dout, 64'hE1);
        do_start();
        chk("ab dout_valid", 64'(kif.dout_valid),  64'd0);
        chk("ab full",       64'(kif.buffer_full), 64'd0);
        chk("ab drop_err",   64'(kif.drop_err),    64'd0);
        send_lane(64'hAB, 1'b1);
        wait_blk("ab");
        clr_exp();
        exp_blk[0]  = 64'hAB;
        exp_blk[1]  = P_FIRST;
        exp_blk[16] = P_LAST;
        check_block("ab", 1'b1);

        // reset while a block is outstanding
        rst_n = 1'b0;
        #1;
        chk("mr blk_valid", 64'(blk_valid),       64'd0);
        chk("mr blk_last",  64'(blk_last),        64'd0);
        chk("mr full",      64'(kif.buffer_full), 64'd1);
        chk("mr lane0",     blk_data[63:0],       64'd0);
        chk("mr lane16",    blk_data[16*64 +: 64], 64'd0);
        chk("mr ready",     64'(kif.ready),       64'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
